// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared FSM encodings and port indices for the RAM bus arbiter
package mem_bus_arbiter_pkg;
    typedef enum logic [1:0] {
        A_IDLE = 2'd0,
        A_REQ  = 2'd1,
        A_RESP = 2'd2
    } arb_state_e;
    localparam logic P_CPU = 1'b0;
    localparam logic P_MON = 1'b1;
endpackage

// File: rtl/mem_bus_arbiter_arb_slot.sv
// arb_slot: captures one request pulse until its completion, flags pulses that collide
module arb_slot (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:2] adr_i,
    input  logic [31:0] wdata_i,
    input  logic        clr_i,
    output logic        pending_o,
    output logic        we_o,
    output logic [31:2] adr_o,
    output logic [31:0] wdata_o,
    output logic        drop_o
);
    logic        pending_q, pending_d, we_q, load;
    logic [31:2] adr_q;
    logic [31:0] wdata_q;
    // a new pulse may land in the very cycle the previous one completes
    assign load      = req_i & (~pending_q | clr_i);
    assign drop_o    = req_i & pending_q & ~clr_i;
    assign pending_d = load | (pending_q & ~clr_i);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            wdata_q   <= '0;
        end else begin
            pending_q <= pending_d;
            if (load) begin
                we_q    <= we_i;
                adr_q   <= adr_i;
                wdata_q <= wdata_i;
            end
        end
    end
    assign pending_o = pending_q;
    assign we_o      = we_q;
    assign adr_o     = adr_q;
    assign wdata_o   = wdata_q;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of the data-RAM bus between the CPU LSU and the UART monitor
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:2] c_adr,
    input  logic [31:0] c_wdata,
    output logic        c_rvalid,
    output logic        c_wfinish,
    output logic [31:0] c_rdata,
    input  logic        u_read_req,
    input  logic [31:0] u_read_adr,
    input  logic        u_write_req,
    input  logic [31:0] u_write_adr,
    input  logic [31:0] u_write_data,
    output logic        read_valid,
    output logic [31:0] read_data,
    output logic        write_finish,
    output logic        m_req,
    output logic        m_we,
    output logic [31:2] m_adr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        grant_mon,
    output logic        arb_err
);
    arb_state_e  state_q, state_d;
    logic        owner_q, owner_d, last_grant_q, last_grant_d, arb_err_q, arb_err_d;
    logic [31:0] c_rdata_q, read_data_q;
    logic        cpu_pend, cpu_we, cpu_drop, cpu_clr;
    logic        mon_pend, mon_we, mon_drop, mon_clr, mon_req;
    logic [31:2] cpu_adr, mon_adr, mon_adr_in, sel_adr;
    logic [31:0] cpu_wdata, mon_wdata, sel_wdata;
    logic        sel_we, in_resp, capture;
    logic [3:0]  unused_adr_bits;
    assign unused_adr_bits = {u_read_adr[1:0], u_write_adr[1:0]};
    assign in_resp = state_q == A_RESP;
    assign cpu_clr = in_resp & (owner_q == P_CPU);
    assign mon_clr = in_resp & (owner_q == P_MON);
    // a simultaneous monitor read and write keeps the write
    assign mon_req    = u_read_req | u_write_req;
    assign mon_adr_in = u_write_req ? u_write_adr[31:2] : u_read_adr[31:2];

    arb_slot u_cpu_slot (
        .clk(clk), .rst(rst), .req_i(c_req), .we_i(c_we), .adr_i(c_adr), .wdata_i(c_wdata),
        .clr_i(cpu_clr), .pending_o(cpu_pend), .we_o(cpu_we), .adr_o(cpu_adr),
        .wdata_o(cpu_wdata), .drop_o(cpu_drop)
    );
    arb_slot u_mon_slot (
        .clk(clk), .rst(rst), .req_i(mon_req), .we_i(u_write_req), .adr_i(mon_adr_in),
        .wdata_i(u_write_data), .clr_i(mon_clr), .pending_o(mon_pend), .we_o(mon_we),
        .adr_o(mon_adr), .wdata_o(mon_wdata), .drop_o(mon_drop)
    );

    assign sel_we    = (owner_q == P_MON) ? mon_we : cpu_we;
    assign sel_adr   = (owner_q == P_MON) ? mon_adr : cpu_adr;
    assign sel_wdata = (owner_q == P_MON) ? mon_wdata : cpu_wdata;
    assign capture   = (state_q == A_REQ) & m_ack & ~sel_we;
    assign arb_err_d = arb_err_q | cpu_drop | mon_drop | (u_read_req & u_write_req);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        case (state_q)
            A_IDLE: if (cpu_pend | mon_pend) begin
                owner_d = (cpu_pend & mon_pend) ? ~last_grant_q : mon_pend;
                state_d = A_REQ;
            end
            A_REQ: state_d = m_ack ? A_RESP : A_REQ;
            A_RESP: begin
                last_grant_d = owner_q;
                state_d      = A_IDLE;
            end
            default: state_d = A_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= A_IDLE;
            owner_q      <= P_MON;
            last_grant_q <= P_MON;
            arb_err_q    <= 1'b0;
            c_rdata_q    <= '0;
            read_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            arb_err_q    <= arb_err_d;
            if (capture && owner_q == P_CPU) c_rdata_q <= m_rdata;
            if (capture && owner_q == P_MON) read_data_q <= m_rdata;
        end
    end

    assign m_req        = state_q == A_REQ;
    assign m_we         = m_req & sel_we;
    assign m_adr        = m_req ? sel_adr : '0;
    assign m_wdata      = m_req ? sel_wdata : '0;
    assign c_rvalid     = cpu_clr & ~cpu_we;
    assign c_wfinish    = cpu_clr & cpu_we;
    assign read_valid   = mon_clr & ~mon_we;
    assign write_finish = mon_clr & mon_we;
    assign c_rdata      = c_rdata_q;
    assign read_data    = read_data_q;
    assign grant_mon    = (state_q == A_IDLE) ? last_grant_q : owner_q;
    assign arb_err      = arb_err_q;
endmodule
